// File: rtl/hamming_secded_stream_decoder_pkg.sv
// Shared SECDED definitions for the Hamming encoder and decoder paths.
package hamming_secded_stream_decoder_pkg;

  typedef enum logic [1:0] {
    CLEAN,
    CORR,
    UNCORR
  } syn_class_e;

  // Smallest r with 2^r >= data_width + r + 1.
  function automatic int unsigned calc_r(input int unsigned data_width);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (r == 0 && (32'd1 << i) >= data_width + i + 1) r = i;
    end
    return r;
  endfunction

  // Codeword position of data bit idx: non-power-of-two positions from 3 upward.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 3; p < 64; p++) begin
      if (pos == 0 && (p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_stream_decoder_syndrome_calc.sv
// Combinational SECDED check: {overall parity, Hamming syndrome} of a codeword.
module secded_syndrome_calc #(
  parameter int unsigned CW_WIDTH = 13,
  parameter int unsigned R        = 4
) (
  input  logic [CW_WIDTH-1:0] codeword,
  output logic [R:0]          syndrome_c
);

  logic [R-1:0] syn_s;

  always_comb begin
    syn_s = '0;
    for (int unsigned i = 1; i < CW_WIDTH; i++) begin
      if (1'(codeword >> i)) syn_s = syn_s ^ R'(i);
    end
    syndrome_c = {^codeword, syn_s};
  end

endmodule

// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage valid/ready SECDED decoder with saturating error counters and
// first-uncorrectable tag capture.
module hamming_secded_stream_decoder
  import hamming_secded_stream_decoder_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned TAG_WIDTH  = 4,
  localparam int unsigned R          = calc_r(DATA_WIDTH),
  localparam int unsigned CW_WIDTH   = DATA_WIDTH + R + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CW_WIDTH-1:0]   in_codeword,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_corrected,
  output logic                  out_uncorrectable,
  output logic [R:0]            out_syndrome,
  input  logic                  clr_counts,
  output logic [15:0]           corr_count,
  output logic [15:0]           uncorr_count,
  output logic                  err_tag_valid,
  output logic [TAG_WIDTH-1:0]  err_tag
);

  logic                  s1_valid_q, s1_valid_d;
  logic [CW_WIDTH-1:0]   s1_cw_q, s1_cw_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;
  logic [R:0]            s1_syn_q, s1_syn_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic                  out_corr_q, out_corr_d;
  logic                  out_uncorr_q, out_uncorr_d;
  logic [R:0]            out_syn_q, out_syn_d;
  logic [15:0]           corr_count_q, corr_count_d;
  logic [15:0]           uncorr_count_q, uncorr_count_d;
  logic                  err_tag_valid_q, err_tag_valid_d;
  logic [TAG_WIDTH-1:0]  err_tag_q, err_tag_d;

  logic [R:0]            syn_c;
  logic                  s2_ready_c;
  logic                  out_fire_c;
  syn_class_e            cls_c;
  logic [CW_WIDTH-1:0]   fixed_cw_c;
  logic [DATA_WIDTH-1:0] ext_data_c;
  logic                  unused_check_bits;

  secded_syndrome_calc #(
    .CW_WIDTH (CW_WIDTH),
    .R        (R)
  ) u_syndrome (
    .codeword   (in_codeword),
    .syndrome_c (syn_c)
  );

  assign s2_ready_c = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_ready_c;
  assign out_fire_c = out_valid_q && out_ready;

  // Classify the S1 word and flip the indicated bit for a correctable error.
  always_comb begin
    cls_c      = CLEAN;
    fixed_cw_c = s1_cw_q;
    if (s1_syn_q[R-1:0] == '0) begin
      if (s1_syn_q[R]) cls_c = CORR;
    end else if (!s1_syn_q[R]) begin
      cls_c = UNCORR;
    end else if (32'(s1_syn_q[R-1:0]) > CW_WIDTH - 1) begin
      cls_c = UNCORR;
    end else begin
      cls_c      = CORR;
      fixed_cw_c = s1_cw_q ^ (CW_WIDTH'(1) << s1_syn_q[R-1:0]);
    end
  end

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_extract
    assign ext_data_c[g] = fixed_cw_c[data_pos(g)];
  end

  // Check-bit positions carry no payload once the syndrome is known.
  assign unused_check_bits = ^fixed_cw_c;

  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_cw_d         = s1_cw_q;
    s1_tag_d        = s1_tag_q;
    s1_syn_d        = s1_syn_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_tag_d       = out_tag_q;
    out_corr_d      = out_corr_q;
    out_uncorr_d    = out_uncorr_q;
    out_syn_d       = out_syn_q;
    corr_count_d    = corr_count_q;
    uncorr_count_d  = uncorr_count_q;
    err_tag_valid_d = err_tag_valid_q;
    err_tag_d       = err_tag_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cw_d  = in_codeword;
        s1_tag_d = in_tag;
        s1_syn_d = syn_c;
      end
    end

    if (s2_ready_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = ext_data_c;
        out_tag_d    = s1_tag_q;
        out_corr_d   = (cls_c == CORR);
        out_uncorr_d = (cls_c == UNCORR);
        out_syn_d    = s1_syn_q;
      end
    end

    if (out_fire_c && out_corr_q && corr_count_q != 16'hFFFF)
      corr_count_d = corr_count_q + 16'd1;
    if (out_fire_c && out_uncorr_q && uncorr_count_q != 16'hFFFF)
      uncorr_count_d = uncorr_count_q + 16'd1;
    if (out_fire_c && out_uncorr_q && !err_tag_valid_q) begin
      err_tag_valid_d = 1'b1;
      err_tag_d       = out_tag_q;
    end

    if (clr_counts) begin
      corr_count_d    = '0;
      uncorr_count_d  = '0;
      err_tag_valid_d = 1'b0;
      err_tag_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_cw_q         <= '0;
      s1_tag_q        <= '0;
      s1_syn_q        <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_tag_q       <= '0;
      out_corr_q      <= 1'b0;
      out_uncorr_q    <= 1'b0;
      out_syn_q       <= '0;
      corr_count_q    <= '0;
      uncorr_count_q  <= '0;
      err_tag_valid_q <= 1'b0;
      err_tag_q       <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_cw_q         <= s1_cw_d;
      s1_tag_q        <= s1_tag_d;
      s1_syn_q        <= s1_syn_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_tag_q       <= out_tag_d;
      out_corr_q      <= out_corr_d;
      out_uncorr_q    <= out_uncorr_d;
      out_syn_q       <= out_syn_d;
      corr_count_q    <= corr_count_d;
      uncorr_count_q  <= uncorr_count_d;
      err_tag_valid_q <= err_tag_valid_d;
      err_tag_q       <= err_tag_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_tag           = out_tag_q;
  assign out_corrected     = out_corr_q;
  assign out_uncorrectable = out_uncorr_q;
  assign out_syndrome      = out_syn_q;
  assign corr_count        = corr_count_q;
  assign uncorr_count      = uncorr_count_q;
  assign err_tag_valid     = err_tag_valid_q;
  assign err_tag           = err_tag_q;

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Scoreboard bench for hamming_secded_stream_decoder at DATA_WIDTH=8.
module tb_hamming_secded_stream_decoder;

  localparam int unsigned DW = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 13;
  localparam int unsigned SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_codeword = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_corrected;
  logic          out_uncorrectable;
  logic [SW-1:0] out_syndrome;
  logic          clr_counts = 1'b0;
  logic [15:0]   corr_count;
  logic [15:0]   uncorr_count;
  logic          err_tag_valid;
  logic [TW-1:0] err_tag;

  always #5 clk = ~clk;

  hamming_secded_stream_decoder #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_codeword       (in_codeword),
    .in_tag            (in_tag),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_tag           (out_tag),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_syndrome      (out_syndrome),
    .clr_counts        (clr_counts),
    .corr_count        (corr_count),
    .uncorr_count      (uncorr_count),
    .err_tag_valid     (err_tag_valid),
    .err_tag           (err_tag)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          corr;
    logic          uncorr;
    logic [SW-1:0] syn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   DPOS [DW] = '{3, 5, 6, 7, 9, 10, 11, 12};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw;
    logic          par;
    cw = '0;
    for (int k = 0; k < DW; k++) cw[DPOS[k]] = d[k];
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int i = 3; i < CW; i++) if (i[j]) par = par ^ cw[i];
      cw[1 << j] = par;
    end
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

  function automatic exp_t model(input logic [CW-1:0] cw_in, input logic [TW-1:0] tag);
    logic [CW-1:0] cw;
    int            s;
    logic          p;
    exp_t          e;
    cw = cw_in;
    s = 0;
    for (int i = 1; i < CW; i++) if (cw[i]) s = s ^ i;
    p = ^cw;
    e.tag = tag;
    e.corr = 1'b0;
    e.uncorr = 1'b0;
    e.syn = {p, 4'(s)};
    if (s != 0 && !p) e.uncorr = 1'b1;
    else if (s >= CW) e.uncorr = 1'b1;
    else if (p) begin
      e.corr = 1'b1;
      if (s != 0) cw[s] = ~cw[s];
    end
    for (int k = 0; k < DW; k++) e.data[k] = cw[DPOS[k]];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] cw, input logic [TW-1:0] tag, input exp_t e, input bit rand_bp);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_codeword = cw;
    in_tag = tag;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        sb.push_back(e);
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) check_eq("accept_timeout", 32'(done), 1);
  endtask

  task automatic send_exp(input logic [CW-1:0] cw, input logic [TW-1:0] tag, input logic [DW-1:0] d,
                          input logic corr, input logic uncorr, input logic [SW-1:0] syn);
    exp_t e;
    e.data = d; e.tag = tag; e.corr = corr; e.uncorr = uncorr; e.syn = syn;
    send(cw, tag, e, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 50 && (sb.size() != 0 || out_valid); n++) @(negedge clk);
    check_eq("drain", 32'(sb.size()), 0);
    step();
  endtask

  task automatic check_reset_values();
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_tag", 32'(out_tag), 0);
    check_eq("rst_corrected", 32'(out_corrected), 0);
    check_eq("rst_uncorrectable", 32'(out_uncorrectable), 0);
    check_eq("rst_syndrome", 32'(out_syndrome), 0);
    check_eq("rst_corr_count", 32'(corr_count), 0);
    check_eq("rst_uncorr_count", 32'(uncorr_count), 0);
    check_eq("rst_err_tag_valid", 32'(err_tag_valid), 0);
    check_eq("rst_err_tag", 32'(err_tag), 0);
  endtask

  // Output monitor: scoreboard pop, flag exclusivity and hold-while-stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_eq("stall_stable", 32'({out_data, out_tag, out_corrected, out_uncorrectable, out_syndrome}), prev_out);
      if (out_valid) check_eq("flag_excl", 32'(out_corrected & out_uncorrectable), 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 32'(out_valid), 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("out_data", 32'(out_data), 32'(mon_e.data));
          check_eq("out_tag", 32'(out_tag), 32'(mon_e.tag));
          check_eq("out_corrected", 32'(out_corrected), 32'(mon_e.corr));
          check_eq("out_uncorrectable", 32'(out_uncorrectable), 32'(mon_e.uncorr));
          check_eq("out_syndrome", 32'(out_syndrome), 32'(mon_e.syn));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = 32'({out_data, out_tag, out_corrected, out_uncorrectable, out_syndrome});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [CW-1:0] cw;
    int            nerr;
    int            b1;
    int            b2;

    #2;
    check_reset_values();
    step(); step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;

    // Clean words and two-cycle latency
    send_exp(13'h144E, 4'h1, 8'hA5, 1'b0, 1'b0, 5'h00);
    @(negedge clk);
    check_eq("latency_c1", 32'(out_valid), 0);
    @(negedge clk);
    check_eq("latency_c2", 32'(out_valid), 1);
    step();
    drain();
    send_exp(13'h1EEE, 4'h2, 8'hFF, 1'b0, 1'b0, 5'h00);
    drain();
    check_eq("corr_count_clean", 32'(corr_count), 0);

    // Single errors, including bit 0
    send_exp(13'h140E, 4'h3, 8'hA5, 1'b1, 1'b0, 5'h16);
    drain();
    check_eq("corr_count_1", 32'(corr_count), 1);
    send_exp(13'h144F, 4'h4, 8'hA5, 1'b1, 1'b0, 5'h10);
    drain();
    check_eq("corr_count_2", 32'(corr_count), 2);

    // Double error captures the tag; out-of-range syndrome does not overwrite it
    send_exp(13'h1466, 4'h5, 8'hA6, 1'b0, 1'b1, 5'h06);
    drain();
    check_eq("uncorr_count_1", 32'(uncorr_count), 1);
    check_eq("err_tag_valid_1", 32'(err_tag_valid), 1);
    check_eq("err_tag_1", 32'(err_tag), 5);
    send_exp(13'h155C, 4'h6, 8'hA5, 1'b0, 1'b1, 5'h1D);
    drain();
    check_eq("uncorr_count_2", 32'(uncorr_count), 2);
    check_eq("err_tag_kept", 32'(err_tag), 5);

    // Both stages full under backpressure
    out_ready = 1'b0;
    send_exp(13'h144E, 4'h7, 8'hA5, 1'b0, 1'b0, 5'h00);
    send_exp(13'h1EEE, 4'h8, 8'hFF, 1'b0, 1'b0, 5'h00);
    in_valid = 1'b1;
    in_codeword = 13'h144F;
    @(negedge clk);
    check_eq("in_ready_full", 32'(in_ready), 0);
    check_eq("out_valid_full", 32'(out_valid), 1);
    step(); step();
    out_ready = 1'b1;
    send_exp(13'h144F, 4'h9, 8'hA5, 1'b1, 1'b0, 5'h10);
    drain();

    // Random stream with random backpressure and 0..2 injected errors
    for (int w = 0; w < 10; w++) begin
      d = 8'($urandom);
      cw = encode(d);
      nerr = $urandom_range(0, 2);
      b1 = $urandom_range(0, CW - 1);
      b2 = (b1 + $urandom_range(1, CW - 1)) % CW;
      if (nerr >= 1) cw[b1] = ~cw[b1];
      if (nerr == 2) cw[b2] = ~cw[b2];
      send(cw, 4'(w), model(cw, 4'(w)), 1'b1);
    end
    drain();

    // Saturation
    force dut.corr_count_q = 16'hFFFF;
    step();
    release dut.corr_count_q;
    step();
    send_exp(13'h140E, 4'h1, 8'hA5, 1'b1, 1'b0, 5'h16);
    drain();
    check_eq("corr_saturate", 32'(corr_count), 32'hFFFF);

    // Clear wins over a same-cycle flagged handshake
    out_ready = 1'b0;
    send_exp(13'h1466, 4'hC, 8'hA6, 1'b0, 1'b1, 5'h06);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    check_eq("clr_wait_valid", 32'(out_valid), 1);
    step();
    clr_counts = 1'b1;
    out_ready = 1'b1;
    step();
    clr_counts = 1'b0;
    check_eq("clr_corr", 32'(corr_count), 0);
    check_eq("clr_uncorr", 32'(uncorr_count), 0);
    check_eq("clr_err_tag_valid", 32'(err_tag_valid), 0);
    check_eq("clr_err_tag", 32'(err_tag), 0);
    drain();
    send_exp(13'h155C, 4'hA, 8'hA5, 1'b0, 1'b1, 5'h1D);
    drain();
    check_eq("recapture_valid", 32'(err_tag_valid), 1);
    check_eq("recapture_tag", 32'(err_tag), 32'hA);
    check_eq("recapture_uncorr", 32'(uncorr_count), 1);

    // Reset mid-stream drops in-flight words
    out_ready = 1'b0;
    send_exp(13'h140E, 4'h2, 8'hA5, 1'b1, 1'b0, 5'h16);
    send_exp(13'h144E, 4'h3, 8'hA5, 1'b0, 1'b0, 5'h00);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_values();
    step(); step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_eq("post_reset_no_out", 32'(out_valid), 0);
    end
    step();
    send_exp(13'h1EEE, 4'h4, 8'hFF, 1'b0, 1'b0, 5'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
